pipe_hazard_ctrl: RTL

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_hazard_ctrl.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: pipeline hazard controller.
// Resolves load-use bubbles, LSU back-pressure, branch and exception flushes,
// and emits a one-cycle registered fetch redirect.
// Optional feature: define PIPE_PERF_CNT_EN to add stall/flush counters.

`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module pipe_hazard_ctrl (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   id_valid,
    input  logic                   load_flag_rs1,
    input  logic                   load_flag_rs2,
    input  logic                   lsu_req_valid,
    input  logic                   lsu_req_ready,
    input  logic                   lsu_req_load,
    input  logic                   lsu_resp_valid,
    input  logic                   ex_br_taken,
    input  logic [`DATA_WIDTH-1:0] ex_br_target,
    input  logic                   wb_excp,
    input  logic [`DATA_WIDTH-1:0] wb_excp_pc,
    output logic                   pc_stall,
    output logic                   if_id_stall,
    output logic                   id_ex_stall,
    output logic                   ex_mem_stall,
    output logic                   id_ex_bubble,
    output logic                   mem_wb_bubble,
    output logic                   if_id_flush,
    output logic                   id_ex_flush,
    output logic                   ex_mem_flush,
    output logic                   redirect_en,
    output logic [`DATA_WIDTH-1:0] redirect_pc
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [31:0]            perf_stall_cnt,
    output logic [31:0]            perf_flush_cnt
`endif
);

    localparam logic [1:0] StRun     = 2'd0;
    localparam logic [1:0] StLoadUse = 2'd1;
    localparam logic [1:0] StMemWait = 2'd2;
    localparam logic [1:0] StDrain   = 2'd3;

    logic [1:0]             state_q, state_d;
    logic                   redir_q, redir_d;
    logic [`DATA_WIDTH-1:0] redir_pc_q, redir_pc_d;
    logic                   lsu_hold;
    logic                   load_acc;
    logic                   load_use;

    assign lsu_hold = lsu_req_valid & ~lsu_req_ready;
    // A load whose data arrives in the accept cycle never needs to wait.
    assign load_acc = lsu_req_valid & lsu_req_ready & lsu_req_load & ~lsu_resp_valid;
    assign load_use = id_valid & (load_flag_rs1 | load_flag_rs2);

    // Next-state and stall/flush decode, priority: exception > LSU > branch > load-use.
    always_comb begin
        state_d       = state_q;
        redir_d       = 1'b0;
        redir_pc_d    = redir_pc_q;
        pc_stall      = 1'b0;
        if_id_stall   = 1'b0;
        id_ex_stall   = 1'b0;
        ex_mem_stall  = 1'b0;
        id_ex_bubble  = 1'b0;
        mem_wb_bubble = 1'b0;
        if_id_flush   = 1'b0;
        id_ex_flush   = 1'b0;
        ex_mem_flush  = 1'b0;

        case (state_q)
            StDrain: begin
                // Flushed load still in flight: swallow its response, ignore exceptions.
                if_id_flush   = 1'b1;
                id_ex_flush   = 1'b1;
                ex_mem_flush  = 1'b1;
                mem_wb_bubble = 1'b1;
                if (lsu_resp_valid) state_d = StRun;
            end
            StMemWait: begin
                if (wb_excp) begin
                    if_id_flush   = 1'b1;
                    id_ex_flush   = 1'b1;
                    ex_mem_flush  = 1'b1;
                    mem_wb_bubble = 1'b1;
                    redir_d       = 1'b1;
                    redir_pc_d    = wb_excp_pc;
                    // Response arriving with the exception is discarded right here.
                    state_d       = lsu_resp_valid ? StRun : StDrain;
                end else begin
                    pc_stall      = 1'b1;
                    if_id_stall   = 1'b1;
                    id_ex_stall   = 1'b1;
                    ex_mem_stall  = 1'b1;
                    mem_wb_bubble = 1'b1;
                    if (lsu_resp_valid) state_d = StRun;
                end
            end
            default: begin
                // StRun and StLoadUse; StLoadUse always falls back to StRun.
                state_d = StRun;
                if (wb_excp) begin
                    if_id_flush  = 1'b1;
                    id_ex_flush  = 1'b1;
                    ex_mem_flush = 1'b1;
                    redir_d      = 1'b1;
                    redir_pc_d   = wb_excp_pc;
                end else if (lsu_hold) begin
                    // EX is frozen: any branch is not acted on and not remembered.
                    pc_stall      = 1'b1;
                    if_id_stall   = 1'b1;
                    id_ex_stall   = 1'b1;
                    ex_mem_stall  = 1'b1;
                    mem_wb_bubble = 1'b1;
                end else begin
                    if (ex_br_taken) begin
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                        redir_d     = 1'b1;
                        redir_pc_d  = ex_br_target;
                    end else if (load_use && (state_q == StRun)) begin
                        pc_stall     = 1'b1;
                        if_id_stall  = 1'b1;
                        id_ex_bubble = 1'b1;
                        state_d      = StLoadUse;
                    end
                    if (load_acc) state_d = StMemWait;
                end
            end
        endcase

        // The wrong-path fetch arriving alongside the redirect is also dropped.
        if (redir_q) if_id_flush = 1'b1;
    end

    // State and redirect registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StRun;
            redir_q    <= 1'b0;
            redir_pc_q <= '0;
        end else begin
            state_q    <= state_d;
            redir_q    <= redir_d;
            redir_pc_q <= redir_pc_d;
        end
    end

    assign redirect_en = redir_q;
    assign redirect_pc = redir_pc_q;

`ifdef PIPE_PERF_CNT_EN
    logic [31:0] perf_stall_cnt_q;
    logic [31:0] perf_flush_cnt_q;

    // Free-running wrap-around event counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_cnt_q <= '0;
            perf_flush_cnt_q <= '0;
        end else begin
            if (pc_stall) perf_stall_cnt_q <= perf_stall_cnt_q + 32'd1;
            if (redir_q)  perf_flush_cnt_q <= perf_flush_cnt_q + 32'd1;
        end
    end

    assign perf_stall_cnt = perf_stall_cnt_q;
    assign perf_flush_cnt = perf_flush_cnt_q;
`endif

endmodule
